// File: rtl/ofdm_pkg.sv
// Shared defaults and FSM state types for the OFDM cyclic-prefix inserter.
package ofdm_pkg;

   localparam int DATA_W  = 14;
   localparam int FFT_LEN = 16;
   localparam int CP_LEN  = 4;

   localparam logic [1:0] ERR_NONE = 2'b00;

   typedef enum logic {
      W_IDLE,
      W_FILL
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_CP,
      R_DATA
   } rd_state_e;

endpackage

// File: rtl/cp_pingpong_ram.sv
// Two-bank frame store: one write port, one asynchronous read port and a full flag per bank.
module cp_pingpong_ram #(
   parameter int DATA_W  = 14,
   parameter int FFT_LEN = 16,
   localparam int ADDR_W = $clog2(FFT_LEN)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wr_en,
   input  logic                wr_bank,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [2*DATA_W-1:0] wr_data,
   input  logic                rd_bank,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [2*DATA_W-1:0] rd_data,
   input  logic                set_en,
   input  logic                set_bank,
   input  logic                clr_en,
   input  logic                clr_bank,
   output logic [1:0]          full
);

   logic [2*DATA_W-1:0] mem_q [2*FFT_LEN];
   logic [1:0]          full_q;
   logic [1:0]          full_d;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[{wr_bank, wr_addr}] <= wr_data;
      end
   end

   assign rd_data = mem_q[{rd_bank, rd_addr}];

   // Set and clear always target different banks, so both can land in one cycle.
   always_comb begin
      full_d = full_q;
      if (set_en) begin
         full_d[set_bank] = 1'b1;
      end
      if (clr_en) begin
         full_d[clr_bank] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full_q <= 2'b00;
      end else begin
         full_q <= full_d;
      end
   end

   assign full = full_q;

endmodule

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix inserter: captures IFFT frames into a ping-pong buffer and replays CP + frame.
// Optional OFDM_CP_DROP_CNT_EN adds a saturating drop_count output.
module ofdm_cp_insert #(
   parameter int DATA_W  = ofdm_pkg::DATA_W,
   parameter int FFT_LEN = ofdm_pkg::FFT_LEN,
   parameter int CP_LEN  = ofdm_pkg::CP_LEN
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sink_valid,
   output logic              sink_ready,
   input  logic              sink_sop,
   input  logic              sink_eop,
   input  logic [1:0]        sink_error,
   input  logic [DATA_W-1:0] sink_real,
   input  logic [DATA_W-1:0] sink_imag,
   output logic              source_valid,
   input  logic              source_ready,
   output logic              source_sop,
   output logic              source_eop,
   output logic [1:0]        source_error,
   output logic [DATA_W-1:0] source_real,
   output logic [DATA_W-1:0] source_imag
`ifdef OFDM_CP_DROP_CNT_EN
   ,
   output logic [7:0]        drop_count
`endif
);

   import ofdm_pkg::*;

   localparam int ADDR_W = $clog2(FFT_LEN);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_LEN - 1);
   localparam logic [ADDR_W-1:0] CP_START  = ADDR_W'(FFT_LEN - CP_LEN);

   wr_state_e           w_state_q, w_state_d;
   logic                w_bank_q, w_bank_d;
   logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
   logic [1:0]          w_err_q, w_err_d;
   logic [1:0][1:0]     bank_err_q, bank_err_d;

   rd_state_e           r_state_q, r_state_d;
   logic                r_bank_q, r_bank_d;
   logic [ADDR_W-1:0]   r_addr_q, r_addr_d;

   logic                src_valid_q, src_valid_d;
   logic                src_sop_q, src_sop_d;
   logic                src_eop_q, src_eop_d;
   logic [1:0]          src_err_q, src_err_d;
   logic [DATA_W-1:0]   src_real_q, src_real_d;
   logic [DATA_W-1:0]   src_imag_q, src_imag_d;

   logic                wr_en, set_en, clr_en, drop;
   logic [ADDR_W-1:0]   cur_addr;
   logic [1:0]          err_acc;
   logic [1:0]          full;
   logic [2*DATA_W-1:0] rd_data;
   logic                accept, load;

   cp_pingpong_ram #(
      .DATA_W  (DATA_W),
      .FFT_LEN (FFT_LEN)
   ) u_ram (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en),
      .wr_bank  (w_bank_q),
      .wr_addr  (cur_addr),
      .wr_data  ({sink_real, sink_imag}),
      .rd_bank  (r_bank_q),
      .rd_addr  (r_addr_q),
      .rd_data  (rd_data),
      .set_en   (set_en),
      .set_bank (w_bank_q),
      .clr_en   (clr_en),
      .clr_bank (r_bank_q),
      .full     (full)
   );

   assign sink_ready = ~full[w_bank_q];
   assign accept     = sink_valid && sink_ready;

   // A sop always restarts at address 0 with a fresh error accumulator, from either state.
   always_comb begin
      w_state_d  = w_state_q;
      w_bank_d   = w_bank_q;
      w_addr_d   = w_addr_q;
      w_err_d    = w_err_q;
      bank_err_d = bank_err_q;
      wr_en      = 1'b0;
      set_en     = 1'b0;
      drop       = 1'b0;
      cur_addr   = sink_sop ? '0 : w_addr_q;
      err_acc    = (sink_sop ? ERR_NONE : w_err_q) | sink_error;
      if (accept && (w_state_q == W_FILL || sink_sop)) begin
         wr_en = 1'b1;
         if (sink_eop) begin
            w_state_d = W_IDLE;
            if (cur_addr == LAST_ADDR) begin
               set_en               = 1'b1;
               bank_err_d[w_bank_q] = err_acc;
               w_bank_d             = ~w_bank_q;
            end else begin
               drop = 1'b1;
            end
         end else if (cur_addr == LAST_ADDR) begin
            drop      = 1'b1;
            w_state_d = W_IDLE;
         end else begin
            w_addr_d  = cur_addr + ADDR_W'(1);
            w_err_d   = err_acc;
            w_state_d = W_FILL;
         end
      end
   end

   // The bank is freed once its last sample is captured in the output register,
   // and the next full bank starts immediately so frames stay contiguous.
   always_comb begin
      r_state_d   = r_state_q;
      r_bank_d    = r_bank_q;
      r_addr_d    = r_addr_q;
      clr_en      = 1'b0;
      load        = !src_valid_q || source_ready;
      src_valid_d = src_valid_q;
      src_sop_d   = src_sop_q;
      src_eop_d   = src_eop_q;
      src_err_d   = src_err_q;
      src_real_d  = src_real_q;
      src_imag_d  = src_imag_q;
      if (load) begin
         src_valid_d = 1'b0;
         src_sop_d   = 1'b0;
         src_eop_d   = 1'b0;
      end
      case (r_state_q)
         R_IDLE: begin
            if (full[r_bank_q]) begin
               r_state_d = R_CP;
               r_addr_d  = CP_START;
            end
         end
         R_CP, R_DATA: begin
            if (load) begin
               src_valid_d = 1'b1;
               src_sop_d   = (r_state_q == R_CP) && (r_addr_q == CP_START);
               src_eop_d   = (r_state_q == R_DATA) && (r_addr_q == LAST_ADDR);
               src_err_d   = bank_err_q[r_bank_q];
               src_real_d  = rd_data[2*DATA_W-1:DATA_W];
               src_imag_d  = rd_data[DATA_W-1:0];
               if (r_addr_q != LAST_ADDR) begin
                  r_addr_d = r_addr_q + ADDR_W'(1);
               end else if (r_state_q == R_CP) begin
                  r_state_d = R_DATA;
                  r_addr_d  = '0;
               end else begin
                  clr_en   = 1'b1;
                  r_bank_d = ~r_bank_q;
                  if (full[~r_bank_q]) begin
                     r_state_d = R_CP;
                     r_addr_d  = CP_START;
                  end else begin
                     r_state_d = R_IDLE;
                  end
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_state_q   <= W_IDLE;
         w_bank_q    <= 1'b0;
         w_addr_q    <= '0;
         w_err_q     <= ERR_NONE;
         bank_err_q  <= '0;
         r_state_q   <= R_IDLE;
         r_bank_q    <= 1'b0;
         r_addr_q    <= '0;
         src_valid_q <= 1'b0;
         src_sop_q   <= 1'b0;
         src_eop_q   <= 1'b0;
         src_err_q   <= ERR_NONE;
         src_real_q  <= '0;
         src_imag_q  <= '0;
      end else begin
         w_state_q   <= w_state_d;
         w_bank_q    <= w_bank_d;
         w_addr_q    <= w_addr_d;
         w_err_q     <= w_err_d;
         bank_err_q  <= bank_err_d;
         r_state_q   <= r_state_d;
         r_bank_q    <= r_bank_d;
         r_addr_q    <= r_addr_d;
         src_valid_q <= src_valid_d;
         src_sop_q   <= src_sop_d;
         src_eop_q   <= src_eop_d;
         src_err_q   <= src_err_d;
         src_real_q  <= src_real_d;
         src_imag_q  <= src_imag_d;
      end
   end

   assign source_valid = src_valid_q;
   assign source_sop   = src_sop_q;
   assign source_eop   = src_eop_q;
   assign source_error = src_err_q;
   assign source_real  = src_real_q;
   assign source_imag  = src_imag_q;

`ifdef OFDM_CP_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != 8'hFF) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Self-checking bench for ofdm_cp_insert with a frame-level reference model.
// Checks drop_count as well when OFDM_CP_DROP_CNT_EN is defined.
module tb_ofdm_cp_insert;

   import ofdm_pkg::*;

   localparam int DW = DATA_W;
   localparam int N  = FFT_LEN;
   localparam int CP = CP_LEN;

   typedef struct packed {
      logic          sop;
      logic          eop;
      logic [1:0]    err;
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } out_s;

   logic          clk;
   logic          reset_n;
   logic          sink_valid;
   logic          sink_ready;
   logic          sink_sop;
   logic          sink_eop;
   logic [1:0]    sink_error;
   logic [DW-1:0] sink_real;
   logic [DW-1:0] sink_imag;
   logic          source_valid;
   logic          source_ready;
   logic          source_sop;
   logic          source_eop;
   logic [1:0]    source_error;
   logic [DW-1:0] source_real;
   logic [DW-1:0] source_imag;
`ifdef OFDM_CP_DROP_CNT_EN
   logic [7:0]    drop_count;
`endif

   ofdm_cp_insert dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sink_valid   (sink_valid),
      .sink_ready   (sink_ready),
      .sink_sop     (sink_sop),
      .sink_eop     (sink_eop),
      .sink_error   (sink_error),
      .sink_real    (sink_real),
      .sink_imag    (sink_imag),
      .source_valid (source_valid),
      .source_ready (source_ready),
      .source_sop   (source_sop),
      .source_eop   (source_eop),
      .source_error (source_error),
      .source_real  (source_real),
      .source_imag  (source_imag)
`ifdef OFDM_CP_DROP_CNT_EN
      ,
      .drop_count   (drop_count)
`endif
   );

   out_s expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   lastEopCyc = 0;
   int   firstValidCyc = 0;
   int   outCount = 0;
   int   gaps = 0;
   int   gapTarget = 0;
   int   expDrops = 0;
   int   readyMode = 0;
   int   readyPhase = 0;
   bit   monEn = 0;
   bit   sinkLowSeen = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Downstream ready: always on, the fixed 1,0,0,1 pattern, or random.
   initial begin
      source_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         readyPhase++;
         case (readyMode)
            0:       source_ready = 1'b1;
            1:       source_ready = ((readyPhase % 4) == 0) || ((readyPhase % 4) == 3);
            default: source_ready = ($urandom_range(99) < 60);
         endcase
      end
   end

   // Output monitor: scoreboard, hold-while-stalled, first-valid cycle and gap tracking.
   initial begin
      out_s cur, hv, e;
      bit   holdPend, prevValid;
      holdPend  = 0;
      prevValid = 0;
      hv        = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            holdPend  = 0;
            prevValid = 0;
         end else if (monEn) begin
            cur = '{source_sop, source_eop, source_error, source_real, source_imag};
            if (!sink_ready) sinkLowSeen = 1;
            if (holdPend) checkOutput("hold", 64'(cur), 64'(hv));
            holdPend = source_valid && !source_ready;
            hv       = cur;
            if (source_valid && !prevValid) firstValidCyc = cyc;
            prevValid = source_valid;
            if (outCount > 0 && outCount < gapTarget && !source_valid) gaps++;
            if (source_valid && source_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_out", 64'(cur), 64'(0));
               end else begin
                  e = expQ.pop_front();
                  checkOutput("sample", 64'(cur), 64'(e));
               end
               outCount++;
            end
         end
      end
   end

   // Drives one frame (len samples, eop on index eopAt, errVal on index errIdx) and
   // updates the model: a good frame yields its last CP samples followed by all N.
   task automatic applyStimulus(input int len, input int eopAt, input int errIdx,
                                input logic [1:0] errVal, input bit ramp, input int gapPct);
      logic [DW-1:0] re [N];
      logic [DW-1:0] im [N];
      logic [1:0]    errOr;
      bit            acc;
      int            bound;
      out_s          o;
      errOr = 2'b00;
      for (int i = 0; i < len; i++) begin
         re[i] = ramp ? DW'(i) : DW'($urandom);
         im[i] = ramp ? DW'(100 + i) : DW'($urandom);
         while ($urandom_range(99) < gapPct) begin
            sink_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         sink_valid = 1'b1;
         sink_sop   = (i == 0);
         sink_eop   = (i == eopAt);
         sink_error = (i == errIdx) ? errVal : 2'b00;
         sink_real  = re[i];
         sink_imag  = im[i];
         errOr      = errOr | sink_error;
         bound      = 0;
         do begin
            @(negedge clk);
            acc = sink_ready;
            @(posedge clk);
            #1;
            bound++;
         end while (!acc && bound < 1000);
         if (!acc) checkOutput("sink_timeout", 64'(0), 64'(1));
         if (i == eopAt) lastEopCyc = cyc;
      end
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
      sink_error = 2'b00;
      if (len == N && eopAt == N - 1) begin
         for (int k = 0; k < N + CP; k++) begin
            o.sop = (k == 0);
            o.eop = (k == N + CP - 1);
            o.err = errOr;
            o.re  = re[(k + N - CP) % N];
            o.im  = im[(k + N - CP) % N];
            expQ.push_back(o);
         end
      end else if (len > 0) begin
         expDrops++;
      end
   endtask

   task automatic waitDrain();
      int b;
      b = 0;
      while (expQ.size() > 0 && b < 3000) begin
         @(posedge clk);
         b++;
      end
      if (expQ.size() > 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'(0));
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int b;
      reset_n    = 1'b0;
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
      sink_error = 2'b00;
      sink_real  = '0;
      sink_imag  = '0;
      #1;
      checkOutput("reset_outputs",
                  64'({source_valid, source_sop, source_eop, source_error, source_real, source_imag}),
                  64'(0));
      checkOutput("reset_sink_ready", 64'(sink_ready), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      monEn   = 1;
      @(posedge clk);
      #1;

      $display("[TB] single ramp frame");
      readyMode = 0;
      applyStimulus(N, N - 1, -1, 2'b00, 1, 0);
      waitDrain();
      checkOutput("first_valid_latency", 64'(firstValidCyc - lastEopCyc), 64'(2));

      $display("[TB] three back-to-back frames");
      outCount    = 0;
      gaps        = 0;
      gapTarget   = 3 * (N + CP);
      sinkLowSeen = 0;
      for (int f = 0; f < 3; f++) applyStimulus(N, N - 1, -1, 2'b00, 0, 0);
      waitDrain();
      gapTarget = 0;
      checkOutput("contiguous_gaps", 64'(gaps), 64'(0));
      checkOutput("out_count", 64'(outCount), 64'(3 * (N + CP)));
      checkOutput("sink_ready_dropped", 64'(sinkLowSeen), 64'(1));

      $display("[TB] stalled output 1,0,0,1");
      readyMode = 1;
      applyStimulus(N, N - 1, -1, 2'b00, 1, 0);
      applyStimulus(N, N - 1, -1, 2'b00, 0, 0);
      waitDrain();
      readyMode = 0;

      $display("[TB] early-eop frame then good frame");
      applyStimulus(11, 10, -1, 2'b00, 0, 0);
      applyStimulus(N, N - 1, -1, 2'b00, 0, 0);
      waitDrain();
`ifdef OFDM_CP_DROP_CNT_EN
      checkOutput("drop_count", 64'(drop_count), 64'(expDrops));
`endif

      $display("[TB] error frame then clean frame");
      applyStimulus(N, N - 1, 5, 2'b01, 0, 0);
      applyStimulus(N, N - 1, -1, 2'b00, 0, 0);
      waitDrain();

      $display("[TB] random traffic");
      readyMode = 2;
      for (int f = 0; f < 6; f++) begin
         if (f == 3) applyStimulus(N, -1, -1, 2'b00, 0, 10);
         applyStimulus(N, N - 1, $urandom_range(N - 1), 2'($urandom), 0, 20);
      end
      waitDrain();
`ifdef OFDM_CP_DROP_CNT_EN
      checkOutput("drop_count_random", 64'(drop_count), 64'(expDrops));
`endif
      readyMode = 0;

      $display("[TB] reset mid-output");
      outCount = 0;
      applyStimulus(N, N - 1, -1, 2'b00, 0, 0);
      b = 0;
      while (outCount < 7 && b < 200) begin
         @(posedge clk);
         #2;
         b++;
      end
      checkOutput("reached_sample_7", 64'(outCount >= 7), 64'(1));
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_outputs",
                  64'({source_valid, source_sop, source_eop, source_error, source_real, source_imag}),
                  64'(0));
      expQ.delete();
      expDrops = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_sink_ready", 64'(sink_ready), 64'(1));
`ifdef OFDM_CP_DROP_CNT_EN
      checkOutput("post_reset_drop_count", 64'(drop_count), 64'(0));
`endif
      applyStimulus(N, N - 1, -1, 2'b00, 1, 0);
      waitDrain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] global timeout");
   end

endmodule
